// File: rtl/pid_filter_pkg.sv
// Shared definitions for pid_filter: default widths, config address map,
// derived-width helpers and the signed saturation function.
// Optional feature macro: PID_POLARITY_EN (adds pid_polarity_addr).
package pid_filter_pkg;

    localparam int unsigned PID_W_CHAN    = 5;
    localparam int unsigned PID_N_CHAN    = 8;
    localparam int unsigned PID_W_DATA    = 18;
    localparam int unsigned PID_W_COEF    = 16;
    localparam int unsigned PID_W_OUT     = 18;
    localparam int unsigned PID_W_WR_ADDR = 16;
    localparam int unsigned PID_W_WR_CHAN = 16;
    localparam int unsigned PID_W_WR_DATA = 48;

    localparam logic [15:0] pid_setpoint_addr = 16'h0050;
    localparam logic [15:0] pid_p_coef_addr   = 16'h0051;
    localparam logic [15:0] pid_i_coef_addr   = 16'h0052;
    localparam logic [15:0] pid_d_coef_addr   = 16'h0053;
    localparam logic [15:0] pid_lock_en_addr  = 16'h0054;
    localparam logic [15:0] pid_clr_rqst_addr = 16'h0055;
`ifdef PID_POLARITY_EN
    localparam logic [15:0] pid_polarity_addr = 16'h0056;
`endif

    // error = setpoint - data needs one extra bit
    function automatic int unsigned pid_w_err(input int unsigned w_data);
        return w_data + 1;
    endfunction

    // k0 = p+i+d and k1 = -(p+2d) need two extra bits
    function automatic int unsigned pid_w_k(input int unsigned w_coef);
        return w_coef + 2;
    endfunction

    function automatic int unsigned pid_w_prod(input int unsigned w_k, input int unsigned w_err);
        return w_k + w_err;
    endfunction

    // u plus three products cannot overflow with three guard bits
    function automatic int unsigned pid_w_acc(input int unsigned w_prod);
        return w_prod + 3;
    endfunction

    // Clamp x to the signed range of a w-bit value
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pid_coef_mem.sv
// Per-channel PID configuration register file: setpoint, P/I/D coefficients,
// lock enable and (with PID_POLARITY_EN) error polarity. Combinational read.
module pid_coef_mem
    import pid_filter_pkg::*;
#(
    parameter int unsigned N_CHAN    = PID_N_CHAN,
    parameter int unsigned W_DATA    = PID_W_DATA,
    parameter int unsigned W_COEF    = PID_W_COEF,
    parameter int unsigned W_WR_ADDR = PID_W_WR_ADDR,
    parameter int unsigned W_WR_CHAN = PID_W_WR_CHAN,
    parameter int unsigned W_WR_DATA = PID_W_WR_DATA,
    parameter int unsigned W_IDX     = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [W_WR_ADDR-1:0]        wr_addr_i,
    input  logic [W_WR_CHAN-1:0]        wr_chan_i,
    input  logic [W_WR_DATA-1:0]        wr_data_i,
    input  logic [W_IDX-1:0]            rd_idx_i,
    output logic signed [W_DATA-1:0]    rd_setpoint_o,
    output logic signed [W_COEF-1:0]    rd_p_o,
    output logic signed [W_COEF-1:0]    rd_i_o,
    output logic signed [W_COEF-1:0]    rd_d_o,
`ifdef PID_POLARITY_EN
    output logic                        rd_pol_o,
`endif
    output logic [N_CHAN-1:0]           lock_en_o
);

    logic signed [W_DATA-1:0] setpoint_q [N_CHAN];
    logic signed [W_COEF-1:0] p_q [N_CHAN];
    logic signed [W_COEF-1:0] i_q [N_CHAN];
    logic signed [W_COEF-1:0] d_q [N_CHAN];
    logic [N_CHAN-1:0]        lock_q, lock_d;
`ifdef PID_POLARITY_EN
    logic [N_CHAN-1:0]        pol_q, pol_d;
`endif
    logic                     wr_hit;
    logic [W_IDX-1:0]         wr_idx;
    logic                     unused_wr_bits;

    assign wr_hit         = wr_en_i && (wr_chan_i < W_WR_CHAN'(N_CHAN));
    assign wr_idx         = wr_chan_i[W_IDX-1:0];
    assign unused_wr_bits = ^wr_data_i[W_WR_DATA-1:W_DATA];

    // Setpoint and coefficient storage, intentionally left without reset
    always_ff @(posedge clk_i) begin
        if (wr_hit) begin
            if (wr_addr_i == W_WR_ADDR'(pid_setpoint_addr)) setpoint_q[wr_idx] <= wr_data_i[W_DATA-1:0];
            if (wr_addr_i == W_WR_ADDR'(pid_p_coef_addr))   p_q[wr_idx]        <= wr_data_i[W_COEF-1:0];
            if (wr_addr_i == W_WR_ADDR'(pid_i_coef_addr))   i_q[wr_idx]        <= wr_data_i[W_COEF-1:0];
            if (wr_addr_i == W_WR_ADDR'(pid_d_coef_addr))   d_q[wr_idx]        <= wr_data_i[W_COEF-1:0];
        end
    end

    // Next-state for the reset-able per-channel control bits
    always_comb begin
        lock_d = lock_q;
        if (wr_hit && wr_addr_i == W_WR_ADDR'(pid_lock_en_addr))
            lock_d[wr_idx] = wr_data_i[0];
`ifdef PID_POLARITY_EN
        pol_d = pol_q;
        if (wr_hit && wr_addr_i == W_WR_ADDR'(pid_polarity_addr))
            pol_d[wr_idx] = wr_data_i[0];
`endif
    end

    // Lock enable (and polarity) registers, cleared on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= '0;
`ifdef PID_POLARITY_EN
            pol_q  <= '0;
`endif
        end else begin
            lock_q <= lock_d;
`ifdef PID_POLARITY_EN
            pol_q  <= pol_d;
`endif
        end
    end

    assign rd_setpoint_o = setpoint_q[rd_idx_i];
    assign rd_p_o        = p_q[rd_idx_i];
    assign rd_i_o        = i_q[rd_idx_i];
    assign rd_d_o        = d_q[rd_idx_i];
    assign lock_en_o     = lock_q;
`ifdef PID_POLARITY_EN
    assign rd_pol_o      = pol_q[rd_idx_i];
`endif

endmodule

// File: rtl/pid_filter.sv
// Per-channel velocity-form PID controller, 4-stage pipeline, 1 sample/cycle.
// Optional feature macro: PID_POLARITY_EN (per-channel error negation).
module pid_filter
    import pid_filter_pkg::*;
#(
    parameter int unsigned W_CHAN    = PID_W_CHAN,
    parameter int unsigned N_CHAN    = PID_N_CHAN,
    parameter int unsigned W_DATA    = PID_W_DATA,
    parameter int unsigned W_COEF    = PID_W_COEF,
    parameter int unsigned W_OUT     = PID_W_OUT,
    parameter int unsigned W_WR_ADDR = PID_W_WR_ADDR,
    parameter int unsigned W_WR_CHAN = PID_W_WR_CHAN,
    parameter int unsigned W_WR_DATA = PID_W_WR_DATA
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     dv_in,
    input  logic [W_CHAN-1:0]        chan_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic                     wr_en,
    input  logic [W_WR_ADDR-1:0]     wr_addr,
    input  logic [W_WR_CHAN-1:0]     wr_chan,
    input  logic [W_WR_DATA-1:0]     wr_data,
    output logic                     dv_out,
    output logic [W_CHAN-1:0]        chan_out,
    output logic signed [W_OUT-1:0]  data_out
);

    localparam int unsigned W_IDX  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int unsigned W_ERR  = pid_w_err(W_DATA);
    localparam int unsigned W_K    = pid_w_k(W_COEF);
    localparam int unsigned W_PROD = pid_w_prod(W_K, W_ERR);
    localparam int unsigned W_ACC  = pid_w_acc(W_PROD);

    // config read port and per-channel control
    logic signed [W_DATA-1:0] sp_rd;
    logic signed [W_COEF-1:0] p_rd, i_rd, d_rd;
    logic [N_CHAN-1:0]        lock_en, clr_q, clr_d, flush;
`ifdef PID_POLARITY_EN
    logic                     pol_rd, pol1_q;
`endif

    // per-channel controller state
    logic signed [W_ERR-1:0] e1_q [N_CHAN];
    logic signed [W_ERR-1:0] e2_q [N_CHAN];
    logic signed [W_OUT-1:0] u_q  [N_CHAN];

    logic [W_IDX-1:0] in_idx;
    logic             in_ok;

    // S1
    logic                     dv1_q;
    logic [W_CHAN-1:0]        chan1_q;
    logic [W_IDX-1:0]         idx1_q;
    logic signed [W_DATA-1:0] data1_q, sp1_q;
    logic signed [W_COEF-1:0] p1_q, i1_q, d1_q;
    logic signed [W_ERR-1:0]  e1_1_q, e2_1_q;
    logic signed [W_OUT-1:0]  u1_q;
    // S2
    logic                     dv2_q;
    logic [W_CHAN-1:0]        chan2_q;
    logic [W_IDX-1:0]         idx2_q;
    logic signed [W_ERR-1:0]  e0_d, e0_2_q, e1_2_q, e2_2_q;
    logic signed [W_K-1:0]    k0_d, k1_d, k2_d, k0_2_q, k1_2_q, k2_2_q;
    logic signed [W_OUT-1:0]  u2_q;
    // S3
    logic                     dv3_q;
    logic [W_CHAN-1:0]        chan3_q;
    logic [W_IDX-1:0]         idx3_q;
    logic signed [W_PROD-1:0] pr0_3_q, pr1_3_q, pr2_3_q;
    logic signed [W_ERR-1:0]  e0_3_q, e1_3_q;
    logic signed [W_OUT-1:0]  u3_q;
    // S4
    logic signed [W_ACC-1:0]  acc_d;
    logic signed [63:0]       sat64_d;
    logic signed [W_OUT-1:0]  sat_d;
    logic                     wb;
    logic                     unused_wr_bits;

    pid_coef_mem #(
        .N_CHAN    (N_CHAN),
        .W_DATA    (W_DATA),
        .W_COEF    (W_COEF),
        .W_WR_ADDR (W_WR_ADDR),
        .W_WR_CHAN (W_WR_CHAN),
        .W_WR_DATA (W_WR_DATA),
        .W_IDX     (W_IDX)
    ) u_coef_mem (
        .clk_i         (clk_in),
        .rst_ni        (rst_in),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_chan_i     (wr_chan),
        .wr_data_i     (wr_data),
        .rd_idx_i      (in_idx),
        .rd_setpoint_o (sp_rd),
        .rd_p_o        (p_rd),
        .rd_i_o        (i_rd),
        .rd_d_o        (d_rd),
`ifdef PID_POLARITY_EN
        .rd_pol_o      (pol_rd),
`endif
        .lock_en_o     (lock_en)
    );

    assign unused_wr_bits = ^wr_data[W_WR_DATA-1:1];
    assign in_idx = chan_in[W_IDX-1:0];
    // a cleared or unlocked channel drops its samples at every stage
    assign flush  = clr_q | ~lock_en;
    assign in_ok  = dv_in && ({1'b0, chan_in} < (W_CHAN+1)'(N_CHAN)) && !flush[in_idx];
    assign wb     = dv3_q && !flush[idx3_q];

    // One-cycle clear request decode
    always_comb begin
        clr_d = '0;
        if (wr_en && wr_addr == W_WR_ADDR'(pid_clr_rqst_addr)
            && wr_chan < W_WR_CHAN'(N_CHAN) && wr_data[0])
            clr_d[wr_chan[W_IDX-1:0]] = 1'b1;
    end

    // Clear request register, self-clearing
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) clr_q <= '0;
        else         clr_q <= clr_d;
    end

    // S2 arithmetic: error and velocity-form gains
    always_comb begin
`ifdef PID_POLARITY_EN
        e0_d = pol1_q ? (W_ERR'(data1_q) - W_ERR'(sp1_q)) : (W_ERR'(sp1_q) - W_ERR'(data1_q));
`else
        e0_d = W_ERR'(sp1_q) - W_ERR'(data1_q);
`endif
        k0_d = W_K'(p1_q) + W_K'(i1_q) + W_K'(d1_q);
        k1_d = -(W_K'(p1_q) + (W_K'(d1_q) <<< 1));
        k2_d = W_K'(d1_q);
    end

    // S4 arithmetic: accumulate and clamp to the output range
    always_comb begin
        acc_d   = W_ACC'(u3_q) + W_ACC'(pr0_3_q) + W_ACC'(pr1_3_q) + W_ACC'(pr2_3_q);
        sat64_d = saturate(64'(acc_d), W_OUT);
        sat_d   = sat64_d[W_OUT-1:0];
    end

    // Pipeline registers S1..S4 and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dv1_q <= 1'b0; chan1_q <= '0; idx1_q <= '0; data1_q <= '0; sp1_q <= '0;
            p1_q <= '0; i1_q <= '0; d1_q <= '0; e1_1_q <= '0; e2_1_q <= '0; u1_q <= '0;
`ifdef PID_POLARITY_EN
            pol1_q <= 1'b0;
`endif
            dv2_q <= 1'b0; chan2_q <= '0; idx2_q <= '0; e0_2_q <= '0; e1_2_q <= '0; e2_2_q <= '0;
            k0_2_q <= '0; k1_2_q <= '0; k2_2_q <= '0; u2_q <= '0;
            dv3_q <= 1'b0; chan3_q <= '0; idx3_q <= '0; pr0_3_q <= '0; pr1_3_q <= '0;
            pr2_3_q <= '0; e0_3_q <= '0; e1_3_q <= '0; u3_q <= '0;
            dv_out <= 1'b0; chan_out <= '0; data_out <= '0;
        end else begin
            dv1_q   <= in_ok;
            chan1_q <= chan_in;
            idx1_q  <= in_idx;
            data1_q <= data_in;
            sp1_q   <= sp_rd;
            p1_q    <= p_rd;
            i1_q    <= i_rd;
            d1_q    <= d_rd;
            e1_1_q  <= e1_q[in_idx];
            e2_1_q  <= e2_q[in_idx];
            u1_q    <= u_q[in_idx];
`ifdef PID_POLARITY_EN
            pol1_q  <= pol_rd;
`endif
            dv2_q   <= dv1_q && !flush[idx1_q];
            chan2_q <= chan1_q;
            idx2_q  <= idx1_q;
            e0_2_q  <= e0_d;
            e1_2_q  <= e1_1_q;
            e2_2_q  <= e2_1_q;
            k0_2_q  <= k0_d;
            k1_2_q  <= k1_d;
            k2_2_q  <= k2_d;
            u2_q    <= u1_q;

            dv3_q   <= dv2_q && !flush[idx2_q];
            chan3_q <= chan2_q;
            idx3_q  <= idx2_q;
            pr0_3_q <= W_PROD'(k0_2_q) * W_PROD'(e0_2_q);
            pr1_3_q <= W_PROD'(k1_2_q) * W_PROD'(e1_2_q);
            pr2_3_q <= W_PROD'(k2_2_q) * W_PROD'(e2_2_q);
            e0_3_q  <= e0_2_q;
            e1_3_q  <= e1_2_q;
            u3_q    <= u2_q;

            dv_out  <= wb;
            if (wb) begin
                chan_out <= chan3_q;
                data_out <= sat_d;
            end
        end
    end

    // Channel state: zeroed while cleared/unlocked, else written back from S4
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned ch = 0; ch < N_CHAN; ch++) begin
                e1_q[ch] <= '0;
                e2_q[ch] <= '0;
                u_q[ch]  <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < N_CHAN; ch++) begin
                if (flush[ch]) begin
                    e1_q[ch] <= '0;
                    e2_q[ch] <= '0;
                    u_q[ch]  <= '0;
                end else if (wb && idx3_q == W_IDX'(ch)) begin
                    u_q[ch]  <= sat_d;
                    e2_q[ch] <= e1_3_q;
                    e1_q[ch] <= e0_3_q;
                end
            end
        end
    end

endmodule

// File: doc/pid_filter.md
Name: pid_filter

Overview:
Per-channel discrete PID controller directly downstream of oversample_filter. Consumes its (dv, chan, data) stream and computes a velocity-form PID update per channel against a programmable setpoint. Emits a saturated (dv, chan, data) stream to the output router and DAC stages. Channel state and coefficients live in per-channel memories, written through the standard wr_en/wr_addr/wr_chan/wr_data bus.

Parameters:
W_CHAN, 5, channel index width
N_CHAN, 8, number of channels
W_DATA, 18, signed input data width
W_COEF, 16, signed P/I/D coefficient width
W_OUT, 18, signed output width (saturation bound)
W_WR_ADDR, 16, write address width
W_WR_CHAN, 16, write channel width
W_WR_DATA, 48, write data width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-low
dv_in  in  1  input sample valid (oversample_filter dv_out)
chan_in  in  W_CHAN  input channel
data_in  in  W_DATA  signed input sample
wr_en  in  1  config write strobe
wr_addr  in  W_WR_ADDR  config address (ep_map.vh)
wr_chan  in  W_WR_CHAN  config target channel
wr_data  in  W_WR_DATA  config data
dv_out  out  1  output valid
chan_out  out  W_CHAN  output channel
data_out  out  W_OUT  signed controller output

Behaviour:
- Reset (rst_in=0, async): dv_out=0, chan_out=0, data_out=0; all pipe registers, e1/e2/u state and clr requests zeroed; lock_en cleared for every channel. Coefficients and setpoints are not reset.
- Config addresses from ep_map.vh: pid_setpoint_addr, pid_p_coef_addr, pid_i_coef_addr, pid_d_coef_addr (low W_DATA / W_COEF bits, signed), pid_lock_en_addr (bit0), pid_clr_rqst_addr (bit0). Writes take effect the next cycle.
- clr_rqst[ch] self-clears after one cycle. While set, it zeroes e1/e2/u[ch] and flushes that channel's dv at every stage.
- Pipeline (latency 4 cycles, dv_in to dv_out, throughput 1/cycle):
  - S1: register the instruction; fetch setpoint, p, i, d, e1, e2, u for chan_in.
  - S2: e0 = setpoint - data (W_DATA+1); k0 = p+i+d, k1 = -(p+2d), k2 = d (each W_COEF+2).
  - S3: products k0*e0, k1*e1, k2*e2, each full width.
  - S4: acc = u + sum of products, full width with no overflow. Saturate to [-2^(W_OUT-1), 2^(W_OUT-1)-1]. Output the saturated value. If dv, write back u = saturated value, e2 = e1, e1 = e0.
- lock_en[ch]=0: the sample is consumed, dv_out stays 0, and e1/e2/u[ch] are held at 0. Re-enabling starts from zero state.
- Same-channel hazard: consecutive same-channel samples must be at least 4 cycles apart. The upstream ADC round-robin guarantees this. Behaviour is undefined otherwise.
- Reset mid-operation: all in-flight samples are discarded; no writeback occurs.
- A config write coinciding with a sample of the same channel in S1: the sample uses the old value.

Optional Feature:
PID_POLARITY_EN: when defined, adds per-channel pid_polarity_addr (bit0, reset 0). Polarity 1 negates e0 in S2 (e0 = data - setpoint). When undefined, there is no polarity register and e0 = setpoint - data always.

Decomposition:
- Shared package/header (functions.vh / ep_map.vh): address constants pid_*_addr, the signed saturate function, and the derived widths W_ERR = W_DATA+1, W_K = W_COEF+2, W_PROD = W_K+W_ERR, W_ACC = W_PROD+3.
- One sub-module: pid_coef_mem, a per-channel config register file covering setpoint, p, i, d, lock_en and optional polarity, with a combinational read port.

Test Plan:
- p=1, i=0, d=0, setpoint=100, lock=1, ch2 data=40 -> after 4 cycles dv_out=1, chan_out=2, data_out=60; next ch2 data=40 -> 60 (e0-e1=0).
- i=1, p=d=0, setpoint=10, data=0 repeated 3x -> outputs 10, 20, 30.
- i=1000, setpoint=131071, data=-131072 -> first output clamps to 131071 and stays there; negative mirror clamps to -131072.
- lock_en=0 on ch1, samples fed -> dv_out never asserts for ch1 while ch0 outputs continue; set lock=1 -> first ch1 output equals k0*e0.
- Clear ch3 mid-stream (state u=500) -> next ch3 output is computed from u=e1=e2=0; other channels are unaffected.
- Assert rst_in=0 with 3 samples in flight -> dv_out=0 immediately and stays 0; after release, the first outputs start from zero state.
